// File: rtl/multiplier_pkg.sv
// Shared definitions for the multiplier slice: product-width helper.
package multiplier_pkg;

   function automatic int unsigned prod_w(input int unsigned n);
      return 2 * n;
   endfunction

endpackage

// File: rtl/multiplier_full_adder.sv
// One-bit full adder cell used to build the multiplier reduction array.
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/multiplier.sv
// Unsigned N x N array multiplier: AND partial-product grid, rippled rows of
// full-adder cells, and a registered 2N-bit product with synchronous reset.
module multiplier
   import multiplier_pkg::*;
#(
   parameter int unsigned N = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N-1:0]         A,
   input  logic [N-1:0]         B,
   output logic [prod_w(N)-1:0] P
);

   localparam int unsigned PW = prod_w(N);

   logic [PW-1:0] w_prod;
   logic [PW-1:0] r_p;

   // Each row i keeps an (N+1)-bit running sum covering weights 2^i..2^(i+N);
   // its LSB is final product bit i, the rest feeds the next row shifted down.
   for (genvar i = 0; i < N; i++) begin : g_row
      logic [N-1:0] w_pp;
      logic [N:0]   w_acc;

      assign w_pp = A & {N{B[i]}};

      if (i == 0) begin : g_first
         assign w_acc = {1'b0, w_pp};
      end else begin : g_add
         for (genvar j = 0; j < N; j++) begin : g_cell
            logic w_cin;
            logic w_co;

            if (j == 0) begin : g_ha
               assign w_cin = 1'b0;
            end else begin : g_fa
               assign w_cin = g_cell[j-1].w_co;
            end

            full_adder u_fa (
               .a    (g_row[i-1].w_acc[j+1]),
               .b    (w_pp[j]),
               .cin  (w_cin),
               .sum  (w_acc[j]),
               .cout (w_co)
            );
         end
         assign w_acc[N] = g_cell[N-1].w_co;
      end

      if (i < N - 1) begin : g_low
         assign w_prod[i] = w_acc[0];
      end else begin : g_high
         assign w_prod[PW-1:N-1] = w_acc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_p <= '0;
      end else begin
         r_p <= w_prod;
      end
   end

   assign P = r_p;

endmodule

// File: tb/tb_multiplier.sv
// Directed and exhaustive self-checking bench for the 3x3 registered multiplier.
module tb_multiplier;

   logic       clk;
   logic       rst;
   logic [2:0] A;
   logic [2:0] B;
   logic [5:0] P;

   int unsigned n_tests;
   int unsigned n_fail;

   multiplier #(.N(3)) dut (
      .clk (clk),
      .rst (rst),
      .A   (A),
      .B   (B),
      .P   (P)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [5:0] exp);
      n_tests++;
      if (P !== exp) begin
         n_fail++;
         $display("FAIL %s: got P=%0d (%b) expected %0d (%b)", name, P, P, exp, exp);
      end
   endtask

   task automatic test_reset();
      A   = 3'b111;
      B   = 3'b111;
      rst = 1'b1;
      step();
      check("reset_edge1", 6'd0);
      step();
      check("reset_edge2", 6'd0);
      rst = 1'b0;
      step();
      check("reset_release", 6'd49);
   endtask

   task automatic test_latency();
      A = 3'd3;
      B = 3'd5;
      step();
      check("latency_k", 6'd15);
      A = 3'd2;
      B = 3'd2;
      step();
      check("latency_k1", 6'd4);
      // Operand changes between edges must not reach P.
      A = 3'd7;
      B = 3'd7;
      #2;
      check("hold_between_edges", 6'd4);
      A = 3'd0;
      #1;
      check("hold_glitch", 6'd4);
   endtask

   task automatic test_boundaries();
      A = 3'd0; B = 3'd7; step(); check("zero_a", 6'd0);
      A = 3'd7; B = 3'd0; step(); check("zero_b", 6'd0);
      A = 3'd1; B = 3'd6; step(); check("ident_a", 6'd6);
      A = 3'd5; B = 3'd1; step(); check("ident_b", 6'd5);
   endtask

   task automatic test_carry();
      A = 3'd7; B = 3'd7; step(); check("carry_7x7", 6'b110001);
      A = 3'd6; B = 3'd7; step(); check("carry_6x7", 6'd42);
      A = 3'd7; B = 3'd5; step(); check("carry_7x5", 6'd35);
   endtask

   task automatic test_sweep();
      int unsigned ia;
      int unsigned ib;
      int unsigned exp;
      for (int unsigned k = 0; k < 64; k++) begin
         ia  = k / 8;
         ib  = k % 8;
         A   = ia[2:0];
         B   = ib[2:0];
         rst = (k == 37);
         exp = rst ? 0 : ia * ib;
         step();
         n_tests++;
         if (P !== exp[5:0]) begin
            n_fail++;
            $display("FAIL sweep A=%0d B=%0d rst=%0b: got P=%0d expected %0d",
                     ia, ib, rst, P, exp);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b0;
      A       = '0;
      B       = '0;
      #1;
      test_reset();
      test_latency();
      test_boundaries();
      test_carry();
      test_sweep();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
